// File: rtl/sram_like_mem_slave.sv
// Purpose : responder end of the sram-like bus; fronts a synchronous single-port
//           block RAM (1-cycle read) and answers each accepted request with data_ok.
// Latency : data_ok exactly LATENCY cycles after the address handshake (LATENCY 1..15).
// Backpressure: one outstanding request; addr_ok is low from the handshake until the
//           cycle after data_ok, so a held req is re-accepted every LATENCY+1 cycles.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   req, wr, size, addr,  request side from the master; master holds req until addr_ok
//   wdata
//   addr_ok, data_ok,     handshake, response pulse, read word, misalign/illegal flag
//   rdata, misalign
//   ram_en, ram_wen,      block RAM control; ram_rdata is valid the cycle after a
//   ram_addr, ram_wdata,  ram_en read
//   ram_rdata

module sram_like_mem_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [31:0]           rdata,
    output logic                  misalign,
    output logic                  ram_en,
    output logic [3:0]            ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        wr_q;
    logic        mis_q;
    logic        first_q;
    logic [31:0] cap_q;
    logic [31:0] rdata_q;

    logic        hs;
    logic        req_mis;
    logic        last;
    logic [3:0]  wen_aligned;
    logic [31:0] resp_data;
    logic        unused_addr_hi;

    // Address bits above the RAM index alias onto the same words.
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    assign ram_addr  = addr[ADDR_WIDTH+1:2];
    assign ram_wdata = wdata;

    // Handshake is gated by rst so nothing is accepted while reset is asserted.
    assign hs   = req && (state == S_IDLE) && !rst;
    assign last = (state == S_WAIT) && (cnt == 4'd0);

    // Illegal size or an address not aligned to the access size.
    always_comb begin
        req_mis = 1'b0;
        case (size)
            2'd0:    req_mis = 1'b0;
            2'd1:    req_mis = addr[0];
            2'd2:    req_mis = (addr[1:0] != 2'b00);
            default: req_mis = 1'b1;
        endcase
    end

    // Lane enables for an aligned write; master already placed data on its lanes.
    always_comb begin
        wen_aligned = 4'b0000;
        case (size)
            2'd0:    wen_aligned = 4'b0001 << addr[1:0];
            2'd1:    wen_aligned = addr[1] ? 4'b1100 : 4'b0011;
            2'd2:    wen_aligned = 4'b1111;
            default: wen_aligned = 4'b0000;
        endcase
    end

    // With LATENCY 1 the response lands in the same cycle the RAM data appears,
    // so the captured copy is not yet available and the RAM output is used directly.
    always_comb begin
        resp_data = 32'd0;
        if (!wr_q) begin
            resp_data = (LATENCY == 1) ? ram_rdata : cap_q;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs)   state_nxt = S_WAIT;
            S_WAIT:  if (last) state_nxt = S_IDLE;
            default:           state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        addr_ok  = 1'b0;
        ram_en   = 1'b0;
        ram_wen  = 4'b0000;
        data_ok  = 1'b0;
        misalign = 1'b0;
        case (state)
            S_IDLE: begin
                addr_ok = req && !rst;
                ram_en  = hs;
                if (hs && wr && !req_mis) begin
                    ram_wen = wen_aligned;
                end
            end
            S_WAIT: begin
                data_ok  = last;
                misalign = last && mis_q;
            end
            default: ;
        endcase
    end

    assign rdata = data_ok ? resp_data : rdata_q;

    // ---------------- transaction bookkeeping ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            first_q <= 1'b0;
            cap_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (hs) begin
                cnt     <= CNT_INIT;
                wr_q    <= wr;
                mis_q   <= req_mis;
                first_q <= 1'b1;
            end else if (state == S_WAIT) begin
                first_q <= 1'b0;
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end
                // RAM output is valid only in the first cycle after the access.
                if (first_q) begin
                    cap_q <= ram_rdata;
                end
            end
            // Keep the last response visible between data_ok pulses.
            if (data_ok) begin
                rdata_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
module tb_sram_like_mem_slave;

    localparam int AW = 8;
    localparam int NI = 3;   // instance i runs with LATENCY = i+1

    logic        clk;
    logic        rst;
    logic        ram_clr;

    logic        req       [NI];
    logic        wr        [NI];
    logic [1:0]  size      [NI];
    logic [31:0] addr      [NI];
    logic [31:0] wdata     [NI];
    logic        addr_ok   [NI];
    logic        data_ok   [NI];
    logic [31:0] rdata     [NI];
    logic        misalign  [NI];
    logic        ram_en    [NI];
    logic [3:0]  ram_wen   [NI];
    logic [AW-1:0] ram_addr [NI];
    logic [31:0] ram_wdata [NI];
    logic [31:0] ram_rdata [NI];

    logic [31:0] ram [NI][2**AW];   // block RAM behind each DUT
    logic [31:0] mdl [NI][2**AW];   // expected memory contents

    int nchk;
    int npass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_like_mem_slave #(.ADDR_WIDTH(AW), .LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req[g]),
            .wr        (wr[g]),
            .size      (size[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .addr_ok   (addr_ok[g]),
            .data_ok   (data_ok[g]),
            .rdata     (rdata[g]),
            .misalign  (misalign[g]),
            .ram_en    (ram_en[g]),
            .ram_wen   (ram_wen[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );
    end

    // Synchronous RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ram_clr) begin
                for (int w = 0; w < 2**AW; w++) ram[i][w] <= 32'd0;
                ram_rdata[i] <= 32'd0;
            end else if (ram_en[i]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wen[i][b]) ram[i][ram_addr[i]][8*b +: 8] <= ram_wdata[i][8*b +: 8];
                ram_rdata[i] <= ram[i][ram_addr[i]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference rules expressed arithmetically.
    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz == 2'd3) return 1'b1;
        nbytes = 1 << sz;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [3:0] ref_wen(input logic w, input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (!w || ref_mis(sz, a)) return 4'd0;
        nbytes = 1 << sz;
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    // One complete transaction on instance i; hold keeps req high through the wait.
    task automatic txn(input int i, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] exp_wen, input logic exp_mis,
                       input logic hold);
        logic [31:0] exp_rd;
        int  idx;
        int  k;
        bit  got;
        idx    = int'(a[AW+1:2]);
        exp_rd = w ? 32'd0 : mdl[i][idx];
        @(negedge clk);
        req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = d;
        #1;
        check("addr_ok_idle", 32'(addr_ok[i]), 32'd1);
        check("ram_en", 32'(ram_en[i]), 32'd1);
        check("ram_wen", 32'(ram_wen[i]), 32'(exp_wen));
        check("ram_addr", 32'(ram_addr[i]), 32'(idx));
        check("ram_wdata", ram_wdata[i], d);
        for (int b = 0; b < 4; b++)
            if (exp_wen[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        if (!hold) req[i] = 1'b0;
        #1;
        got = 0;
        for (k = 1; k <= 20; k++) begin
            if (hold) check("addr_ok_wait", 32'(addr_ok[i]), 32'd0);
            if (data_ok[i]) begin got = 1; break; end
            @(negedge clk); #1;
        end
        req[i] = 1'b0;
        if (!got) begin
            check("data_ok_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(k), 32'(i + 1));
            check("rdata", rdata[i], exp_rd);
            check("misalign", 32'(misalign[i]), 32'(exp_mis));
            @(negedge clk); #1;
            check("data_ok_pulse", 32'(data_ok[i]), 32'd0);
            check("rdata_hold", rdata[i], exp_rd);
        end
        for (int b = 0; b < 4; b++) ;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  wen;
        logic        mis;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int hs_c  [$];
        int dok_c [$];
        logic w;
        logic [1:0] sz;
        logic [31:0] a, d;

        nchk = 0; npass = 0;
        vecs[0]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 32'h0000_0013, 32'h5500_0000, 4'b1000, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 32'h0000_0012, 32'h1234_0000, 4'b1100, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 32'h0000_0011, 32'hFFFF_FFFF, 4'b0000, 1'b1};
        vecs[6]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,         4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 2'd3, 32'h0000_0010, 32'h0,         4'b0000, 1'b1};
        vecs[8]  = '{1'b1, 2'd1, 32'h0000_0011, 32'hFFFF_FFFF, 4'b0000, 1'b1};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0021, 32'h0000_AB00, 4'b0010, 1'b0};
        vecs[10] = '{1'b1, 2'd1, 32'h0000_0020, 32'h0000_CDEF, 4'b0011, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 32'hFFFF_0020, 32'h0,         4'b0000, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 32'h0000_0012, 32'h0,         4'b0000, 1'b1};

        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b1; wr[i] = 1'b0; size[i] = 2'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
            for (int x = 0; x < 2**AW; x++) mdl[i][x] = 32'd0;
        end
        rst = 1'b1; ram_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("rst_addr_ok", 32'(addr_ok[i]), 32'd0);
            check("rst_data_ok", 32'(data_ok[i]), 32'd0);
            check("rst_ram_en", 32'(ram_en[i]), 32'd0);
            check("rst_ram_wen", 32'(ram_wen[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_misalign", 32'(misalign[i]), 32'd0);
            req[i] = 1'b0;
        end
        rst = 1'b0; ram_clr = 1'b0;

        // Directed table on every latency.
        for (int i = 0; i < NI; i++)
            for (int v = 0; v < 13; v++)
                txn(i, vecs[v].w, vecs[v].sz, vecs[v].a, vecs[v].d, vecs[v].wen, vecs[v].mis, !vecs[v].w);
        check("merged_word", mdl[0][4], 32'h1234_BEEF);
        check("ram_word8", ram[2][8], 32'h0000_CDEF);

        // Back-to-back reads with req held, LATENCY 2.
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h10;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (addr_ok[1]) hs_c.push_back(c);
            if (data_ok[1]) begin
                dok_c.push_back(c);
                check("b2b_rdata", rdata[1], mdl[1][4]);
            end
            @(negedge clk);
        end
        req[1] = 1'b0;
        check("b2b_hs_count", 32'(hs_c.size()), 32'd4);
        check("b2b_dok_count", 32'(dok_c.size()), 32'(hs_c.size()));
        for (int n = 0; n < hs_c.size() && n < dok_c.size(); n++) begin
            check("b2b_resp_cycle", 32'(dok_c[n]), 32'(hs_c[n] + 2));
            if (n > 0) check("b2b_spacing", 32'(hs_c[n] - hs_c[n-1]), 32'd3);
        end

        // Reset in the middle of a LATENCY 3 read.
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 32'h10;
        @(negedge clk);
        rst = 1'b1; #1;
        check("midrst_data_ok", 32'(data_ok[2]), 32'd0);
        check("midrst_addr_ok", 32'(addr_ok[2]), 32'd0);
        check("midrst_rdata", rdata[2], 32'd0);
        @(negedge clk);
        rst = 1'b0; req[2] = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                #1; if (data_ok[2]) seen++;
                @(negedge clk);
            end
            check("midrst_no_resp", 32'(seen), 32'd0);
        end
        txn(2, 1'b0, 2'd2, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b0);

        // Randomized traffic against the reference rules.
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 40; t++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = $urandom;
                d  = $urandom;
                txn(i, w, sz, a, d, ref_wen(w, sz, a), ref_mis(sz, a), 1'($urandom_range(0, 1)));
            end
            for (int x = 0; x < 2**AW; x++)
                if (ram[i][x] !== mdl[i][x]) check("ram_contents", ram[i][x], mdl[i][x]);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/sram_like_mem_slave.md
Name: sram_like_mem_slave

Overview:
- Responder (slave) end of the sram-like bus used by the CPU's instruction and data ports: accepts one request at a time, drives a synchronous single-port block RAM (1-cycle read latency), and returns data_ok after a programmable delay.
- Serves as memory model and on-chip RAM front-end for the inst_* and data_* masters of the core.
- Generates byte enables from size and address.

Parameters:
- ADDR_WIDTH, 16, word-address width of backing RAM; RAM index = addr[ADDR_WIDTH+1:2]
- LATENCY, 1, cycles from address handshake to data_ok; legal 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request valid; master holds until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- addr  in  32  byte address
- wdata  in  32  write data, already lane-positioned by master
- addr_ok  out  1  address handshake, request accepted this cycle
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read word, valid when data_ok
- misalign  out  1  pulses with data_ok when the accepted request was misaligned/illegal
- ram_en  out  1  RAM access enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  ADDR_WIDTH  RAM word index
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en read

Behaviour:
- Reset (async assert) values:
  - addr_ok, data_ok, misalign, ram_en = 0; ram_wen = 0, rdata = 0.
  - FSM = IDLE, counter = 0, captured wr/misalign/rdata registers = 0.
  - Reset mid-transaction drops it: no data_ok is ever produced for it.
- FSM states: IDLE, WAIT.
- IDLE:
  - addr_ok = req (combinational).
  - Handshake (req & addr_ok):
    - ram_en = 1 same cycle; ram_addr = addr[ADDR_WIDTH+1:2]; ram_wdata = wdata.
    - Capture wr and misalign flag; counter <= LATENCY-1; go to WAIT.
  - Outside a handshake: ram_en = 0 and ram_wen = 0.
- Byte enables (write, aligned only):
  - size 0: ram_wen = 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - Reads: ram_wen = 0.
- Misaligned/illegal requests:
  - Cases: size 1 with addr[0] = 1; size 2 with addr[1:0] != 0; size 3.
  - Still accepted; ram_wen forced to 0 (no RAM write); read data still returned.
  - misalign = 1 with that data_ok.
- WAIT:
  - addr_ok = 0.
  - First WAIT cycle: capture ram_rdata into rdata register.
  - counter decrements each cycle.
  - When counter == 0: data_ok = 1 for one cycle, then IDLE.
- Response timing:
  - data_ok asserted exactly LATENCY cycles after the handshake cycle.
  - LATENCY = 1: data_ok in first WAIT cycle; rdata bypasses ram_rdata directly.
  - Otherwise rdata comes from the captured register.
- rdata on write response = 0; rdata outside data_ok holds last value.
- Throughput:
  - One transaction every LATENCY+1 cycles; one outstanding maximum.
  - No new accept in the data_ok cycle; next addr_ok earliest the cycle after data_ok.
- Other:
  - req dropping in WAIT has no effect.
  - Address wrap: upper addr bits above ADDR_WIDTH+1 ignored (aliasing).

Test Plan:
- Reset then word write addr 0x10 wdata 0xDEADBEEF, LATENCY=1 -> addr_ok same cycle; ram_wen=4'hF, ram_addr=4; data_ok next cycle, rdata=0, misalign=0.
- Read addr 0x10 after above, LATENCY=3 -> data_ok exactly 3 cycles after handshake with rdata=0xDEADBEEF; addr_ok=0 during WAIT even with req held.
- Byte write size 0 addr 0x13 wdata 0x55000000 -> ram_wen=4'b1000; half write addr 0x12 -> 4'b1100; subsequent word read returns merged word.
- Misaligned: word write addr 0x11 -> ram_wen=0, RAM unchanged, data_ok with misalign=1; size=3 read -> misalign=1, rdata = word at index.
- Back-to-back reads with req held high, LATENCY=2 -> handshakes spaced 3 cycles apart, responses in order, one data_ok per addr_ok.
- Assert rst while in WAIT -> outputs zero immediately, no data_ok afterward; next request after release served normally.
